// File: rtl/fc_pkg.sv
// Shared flow-control definitions: DLLP type codes, tracker FSM states, default counter widths.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fc_pkg;

    localparam int FC_HDR_W  = 8;
    localparam int FC_DATA_W = 12;

    localparam logic [1:0] FC_INITFC1  = 2'b00;
    localparam logic [1:0] FC_INITFC2  = 2'b01;
    localparam logic [1:0] FC_UPDATEFC = 2'b10;

    typedef enum logic [1:0] {
        FC_DISABLED = 2'd0,
        FC_INIT1    = 2'd1,
        FC_INIT2    = 2'd2,
        FC_ACTIVE   = 2'd3
    } fc_state_t;

endpackage

// File: rtl/fc_credit_reg.sv
// One credit class: modulo limit (CL) and consumed (CC) registers with load, add, delta-check and clear.
// Latency: 1 cycle from control strobe to registered output; delta check is combinational on cl_new_i.
// Backpressure: none; every strobe is applied on the next edge.
module fc_credit_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         cl_load_i,
    input  logic [W-1:0] cl_new_i,
    input  logic         cc_zero_i,
    input  logic         cc_add_i,
    input  logic [W-1:0] cc_add_val_i,
    output logic         delta_ok_o,
    output logic [W-1:0] cl_o,
    output logic [W-1:0] cc_o
);

    // Largest forward step a limit may take; anything beyond means the limit moved backwards.
    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] cl_q, cl_d;
    logic [W-1:0] cc_q, cc_d;
    logic [W-1:0] delta;

    assign delta      = cl_new_i - cl_q;
    assign delta_ok_o = (delta <= HALF);
    assign cl_o       = cl_q;
    assign cc_o       = cc_q;

    // Next-state: clear wins, otherwise limit load and consumed add/zero act independently.
    always_comb begin
        cl_d = cl_q;
        cc_d = cc_q;
        if (clr_i) begin
            cl_d = '0;
            cc_d = '0;
        end else begin
            if (cl_load_i) begin
                cl_d = cl_new_i;
            end
            if (cc_zero_i) begin
                cc_d = '0;
            end else if (cc_add_i) begin
                cc_d = cc_q + cc_add_val_i;
            end
        end
    end

    // Credit state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cl_q <= '0;
            cc_q <= '0;
        end else begin
            cl_q <= cl_d;
            cc_q <= cc_d;
        end
    end

endmodule

// File: rtl/fc_tx_credit_tracker.sv
// TX flow-control init handshake, credit-limit latching from FC DLLPs, and consumed-credit accumulation.
// Latency: 1 cycle; every output is registered, no input-to-output combinational path.
// Backpressure: none; sends outside ACTIVE and backward limit updates are dropped and flagged on fc_err_o.
module fc_tx_credit_tracker
    import fc_pkg::*;
#(
    parameter int HDR_W  = FC_HDR_W,
    parameter int DATA_W = FC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              link_up_i,
    input  logic              fc_dllp_valid_i,
    input  logic [1:0]        fc_dllp_type_i,
    input  logic [HDR_W-1:0]  fc_hdr_credit_i,
    input  logic [DATA_W-1:0] fc_data_credit_i,
    input  logic              tlp_send_i,
    input  logic [HDR_W-1:0]  required_hdr_credit_i,
    input  logic [DATA_W-1:0] required_data_credit_i,
    output logic [HDR_W-1:0]  cl_hdr_o,
    output logic [DATA_W-1:0] cl_data_o,
    output logic [HDR_W-1:0]  cc_hdr_o,
    output logic [DATA_W-1:0] cc_data_o,
    output logic              fc_ready_o,
    output logic              fc_err_o
);

    fc_state_t state_q, state_d;
    logic      err_q, err_d;
    logic      cl_load, cc_zero, cc_add, clr;
    logic      hdr_ok, data_ok;
    logic      is_init1, is_init2, is_upd;

    assign is_init1 = fc_dllp_valid_i && (fc_dllp_type_i == FC_INITFC1);
    assign is_init2 = fc_dllp_valid_i && (fc_dllp_type_i == FC_INITFC2);
    assign is_upd   = fc_dllp_valid_i && (fc_dllp_type_i == FC_UPDATEFC);
    assign clr      = !link_up_i;

    // FSM next-state, credit-register controls and sticky error; link drop overrides everything.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cl_load = 1'b0;
        cc_zero = 1'b0;
        cc_add  = 1'b0;
        if (!link_up_i) begin
            state_d = FC_DISABLED;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                FC_DISABLED: state_d = FC_INIT1;
                FC_INIT1: begin
                    if (is_init1) begin
                        cl_load = 1'b1;
                        cc_zero = 1'b1;
                        state_d = FC_INIT2;
                    end
                end
                FC_INIT2: begin
                    if (is_init1) begin
                        cl_load = 1'b1;
                        cc_zero = 1'b1;
                    end else if (is_init2 || is_upd) begin
                        cl_load = 1'b1;
                        state_d = FC_ACTIVE;
                    end
                end
                FC_ACTIVE: begin
                    if (is_upd) begin
                        if (hdr_ok && data_ok) begin
                            cl_load = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = FC_DISABLED;
            endcase
            if (tlp_send_i) begin
                if (state_q == FC_ACTIVE) begin
                    cc_add = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // FSM state and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FC_DISABLED;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    fc_credit_reg #(.W(HDR_W)) u_hdr (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr),
        .cl_load_i    (cl_load),
        .cl_new_i     (fc_hdr_credit_i),
        .cc_zero_i    (cc_zero),
        .cc_add_i     (cc_add),
        .cc_add_val_i (required_hdr_credit_i),
        .delta_ok_o   (hdr_ok),
        .cl_o         (cl_hdr_o),
        .cc_o         (cc_hdr_o)
    );

    fc_credit_reg #(.W(DATA_W)) u_data (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr),
        .cl_load_i    (cl_load),
        .cl_new_i     (fc_data_credit_i),
        .cc_zero_i    (cc_zero),
        .cc_add_i     (cc_add),
        .cc_add_val_i (required_data_credit_i),
        .delta_ok_o   (data_ok),
        .cl_o         (cl_data_o),
        .cc_o         (cc_data_o)
    );

    assign fc_ready_o = (state_q == FC_ACTIVE);
    assign fc_err_o   = err_q;

endmodule
